mem_port_arbiter: RTL

Arbitrates one single-port, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
Generates the pipeline freeze controls for the program counter, IF/ID and the rear pipeline registers.
Its stall outputs are ANDed with the hazard unit's PC_write/IFID_write and OR'd into the rear-register holds.
The MEM stage has fixed priority over IF, because the MEM-stage instruction is older.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_timeout_cnt.sv | 32 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   // Widths shared with the forwarding and hazard units
   localparam int unsigned ARB_ADDR_W  = 32;
   localparam int unsigned ARB_DATA_W  = 32;

   // Access watchdog default and the read data substituted on abort
   localparam int unsigned ARB_TIMEOUT  = 16;
   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

   // Arbiter states: IDLE, data access in flight, fetch in flight
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Access watchdog: counts cycles of an outstanding memory access and flags
// the last permitted cycle so the arbiter can abort instead of hanging.
module arb_timeout_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt;

   // Cycle counter, cleared while no access is outstanding
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-port variable-latency unified memory shared by the
// IF stage (fetch) and the MEM stage (load/store). MEM has priority since
// its instruction is older. Also produces the pipeline freeze controls.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned        ADDR_W   = ARB_ADDR_W,
   parameter int unsigned        DATA_W   = ARB_DATA_W,
   parameter int unsigned        TIMEOUT  = ARB_TIMEOUT,
   parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(ARB_ERR_DATA)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              PC_write,
   output logic              IFID_write,
   output logic              pipe_stall,
   output logic              err
);

   arb_state_t state;
   logic       flush_pend;
   logic       busy;
   logic       expired_c;
   logic       data_req_c;
   logic       fetch_req_c;
   logic       flush_now_c;
   logic       front_ok_c;

   // A request whose valid is showing this cycle is already served
   assign data_req_c  = (mem_rd | mem_wr) & ~mem_valid;
   assign fetch_req_c = if_req & ~if_valid & ~if_flush;
   assign flush_now_c = flush_pend | if_flush;
   assign busy        = (state != ST_IDLE);

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (~busy),
      .en        (busy),
      .expired_c (expired_c)
   );

   // Freeze controls; a redirect must never be blocked by a pending fetch
   assign pipe_stall = data_req_c;
   assign front_ok_c = (~data_req_c & if_flush) | ~(data_req_c | (if_req & ~if_valid));
   assign PC_write   = front_ok_c;
   assign IFID_write = front_ok_c;

   // Arbitration FSM with registered bus request and response outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         ram_req    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         if_valid   <= 1'b0;
         mem_valid  <= 1'b0;
         err        <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (data_req_c) begin
                  ram_addr  <= mem_addr;
                  ram_we    <= mem_wr;
                  ram_wdata <= mem_wdata;
                  ram_req   <= 1'b1;
                  state     <= ST_DATA;
                  if (mem_rd && mem_wr) begin
                     err <= 1'b1;
                  end
               end else if (fetch_req_c) begin
                  ram_addr <= if_addr;
                  ram_we   <= 1'b0;
                  ram_req  <= 1'b1;
                  state    <= ST_INST;
               end
            end
            ST_DATA: begin
               if (ram_ack) begin
                  ram_req   <= 1'b0;
                  state     <= ST_IDLE;
                  mem_valid <= 1'b1;
                  if (!ram_we) begin
                     mem_rdata <= ram_rdata;
                  end
               end else if (expired_c) begin
                  ram_req   <= 1'b0;
                  state     <= ST_IDLE;
                  err       <= 1'b1;
                  mem_valid <= 1'b1;
                  mem_rdata <= ERR_DATA;
               end
            end
            ST_INST: begin
               if (ram_ack) begin
                  ram_req    <= 1'b0;
                  state      <= ST_IDLE;
                  flush_pend <= 1'b0;
                  if (!flush_now_c) begin
                     if_valid <= 1'b1;
                     if_rdata <= ram_rdata;
                  end
               end else if (expired_c) begin
                  ram_req    <= 1'b0;
                  state      <= ST_IDLE;
                  err        <= 1'b1;
                  flush_pend <= 1'b0;
                  if (!flush_now_c) begin
                     if_valid <= 1'b1;
                     if_rdata <= ERR_DATA;
                  end
               end else if (if_flush) begin
                  flush_pend <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ram_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
